// File: rtl/fc_sequencer.sv
// Purpose : sequences the ASCON datapath through encrypt-then-verify and only releases ct/tag when verified.
// Latency : 6 cycles minimum from the req accept edge to the done pulse (2 per ENC/DEC phase + CHK + done).
// Backpress: req is ignored while busy (no queuing); ENC/DEC wait on the datapath ready inputs.
// Optional watchdog: define FC_TIMEOUT_EN to build the per-phase timeout counter (fault code 11).
module fc_sequencer #(
    parameter int y       = 40,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [y-1:0]   plain_text,
    output logic           busy,
    output logic           encryption_start,
    input  logic           encryption_ready,
    input  logic [y-1:0]   cipher_text,
    input  logic [127:0]   tag,
    output logic           decryption_start,
    input  logic           decryption_ready,
    input  logic [y-1:0]   dec_plain_text,
    input  logic [127:0]   dec_tag,
    output logic [y-1:0]   ct_out,
    output logic [127:0]   tag_out,
    output logic           done,
    output logic           fault,
    output logic [1:0]     fault_code
);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_PT   = 2'b01;
    localparam logic [1:0] CODE_TAG  = 2'b10;
    localparam logic [1:0] CODE_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DEC  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    // High during the first cycle of ENC/DEC, when a stale ready from the
    // previous transaction may still be on the datapath outputs.
    logic           first_q, first_d;

    logic [y-1:0]   pt_q, pt_d;
    logic [y-1:0]   ct_q, ct_d;
    logic [127:0]   tag_q, tag_d;
    logic [y-1:0]   dp_q, dp_d;

    logic           busy_q, busy_d;
    logic           enc_start_q, enc_start_d;
    logic           dec_start_q, dec_start_d;
    logic [y-1:0]   ct_out_q, ct_out_d;
    logic [127:0]   tag_out_q, tag_out_d;
    logic           done_q, done_d;
    logic           fault_q, fault_d;
    logic [1:0]     code_q, code_d;

    // Watchdog expiry for the current ENC/DEC phase.
    logic           tmo_hit;
    logic           tmo_abort;

`ifdef FC_TIMEOUT_EN
    logic [CW-1:0]  cnt_q, cnt_d;

    // Watchdog: restarts on entry to ENC/DEC and counts every cycle spent there.
    always_comb begin
        cnt_d = cnt_q;
        if (first_d) begin
            cnt_d = '0;
        end else if (state_q == S_ENC || state_q == S_DEC) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == CW'(TIMEOUT));

    // dec_tag is only observed by the datapath, never compared here.
    logic unused_ok;
    assign unused_ok = ^dec_tag;
`else
    // Without the watchdog ENC/DEC wait for ready indefinitely.
    assign tmo_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{dec_tag, (TIMEOUT == 0), (CW == 0)};
`endif

    // Next-state, capture and registered-output decisions for the transaction.
    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        pt_d      = pt_q;
        ct_d      = ct_q;
        tag_d     = tag_q;
        dp_d      = dp_q;
        ct_out_d  = ct_out_q;
        tag_out_d = tag_out_q;
        done_d    = 1'b0;
        fault_d   = fault_q;
        code_d    = code_q;
        tmo_abort = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    pt_d    = plain_text;
                    fault_d = 1'b0;
                    code_d  = CODE_NONE;
                    state_d = S_ENC;
                    first_d = 1'b1;
                end
            end
            S_ENC: begin
                // Ready beats the watchdog when both land on the same edge.
                if (!first_q && encryption_ready) begin
                    ct_d    = cipher_text;
                    tag_d   = tag;
                    state_d = S_DEC;
                    first_d = 1'b1;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end
            end
            S_DEC: begin
                if (!first_q && decryption_ready) begin
                    dp_d    = dec_plain_text;
                    state_d = S_CHK;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end
            end
            S_CHK: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                // The live tag is re-read here: the datapath holds it stable
                // after ready, so any change since ENC means a late fault.
                if (tag_q != tag) begin
                    fault_d   = 1'b1;
                    code_d    = CODE_TAG;
                    ct_out_d  = '0;
                    tag_out_d = '0;
                end else if (dp_q != pt_q) begin
                    fault_d   = 1'b1;
                    code_d    = CODE_PT;
                    ct_out_d  = '0;
                    tag_out_d = '0;
                end else begin
                    ct_out_d  = ct_q;
                    tag_out_d = tag_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_abort) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            fault_d   = 1'b1;
            code_d    = CODE_TMO;
            ct_out_d  = '0;
            tag_out_d = '0;
        end

        busy_d      = (state_d != S_IDLE);
        enc_start_d = (state_d == S_ENC);
        dec_start_d = (state_d == S_DEC);
    end

    // State, captured operands and registered outputs; reset aborts everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b0;
            pt_q        <= '0;
            ct_q        <= '0;
            tag_q       <= '0;
            dp_q        <= '0;
            busy_q      <= 1'b0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            ct_out_q    <= '0;
            tag_out_q   <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= CODE_NONE;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            tag_q       <= tag_d;
            dp_q        <= dp_d;
            busy_q      <= busy_d;
            enc_start_q <= enc_start_d;
            dec_start_q <= dec_start_d;
            ct_out_q    <= ct_out_d;
            tag_out_q   <= tag_out_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign busy             = busy_q;
    assign encryption_start = enc_start_q;
    assign decryption_start = dec_start_q;
    assign ct_out           = ct_out_q;
    assign tag_out          = tag_out_q;
    assign done             = done_q;
    assign fault            = fault_q;
    assign fault_code       = code_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: emulated datapath, transaction-timeline model, per-cycle compare.
// Latency figures are cycle numbers counted from the accept edge (ENC is cycle 1).
// The watchdog instance runs with TIMEOUT=15; its test depends on FC_TIMEOUT_EN.
module tb_fc_sequencer;
    localparam int Y = 40;
    localparam logic [Y-1:0] PT0  = 40'h0123456789;
    localparam logic [Y-1:0] CT0  = 40'h1234567890;
    localparam logic [127:0] TAG0 = {16{8'hA5}};
    localparam logic [127:0] TAG1 = {16{8'h5A}};

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req = 1'b0;
    logic [Y-1:0]   plain_text = '0;
    logic           encryption_ready = 1'b0;
    logic [Y-1:0]   cipher_text = '0;
    logic [127:0]   tag = '0;
    logic           decryption_ready = 1'b0;
    logic [Y-1:0]   dec_plain_text = '0;
    logic [127:0]   dec_tag = '0;

    logic           busy, encryption_start, decryption_start, done, fault;
    logic [Y-1:0]   ct_out;
    logic [127:0]   tag_out;
    logic [1:0]     fault_code;

    logic           w_busy, w_encryption_start, w_decryption_start, w_done, w_fault;
    logic [Y-1:0]   w_ct_out;
    logic [127:0]   w_tag_out;
    logic [1:0]     w_fault_code;

    fc_sequencer #(.y(Y)) dut (
        .clk(clk), .rst(rst), .req(req), .plain_text(plain_text), .busy(busy),
        .encryption_start(encryption_start), .encryption_ready(encryption_ready),
        .cipher_text(cipher_text), .tag(tag), .decryption_start(decryption_start),
        .decryption_ready(decryption_ready), .dec_plain_text(dec_plain_text), .dec_tag(dec_tag),
        .ct_out(ct_out), .tag_out(tag_out), .done(done), .fault(fault), .fault_code(fault_code)
    );

    fc_sequencer #(.y(Y), .TIMEOUT(15), .CW(4)) dut_wd (
        .clk(clk), .rst(rst), .req(req), .plain_text(plain_text), .busy(w_busy),
        .encryption_start(w_encryption_start), .encryption_ready(encryption_ready),
        .cipher_text(cipher_text), .tag(tag), .decryption_start(w_decryption_start),
        .decryption_ready(decryption_ready), .dec_plain_text(dec_plain_text), .dec_tag(dec_tag),
        .ct_out(w_ct_out), .tag_out(w_tag_out), .done(w_done), .fault(w_fault), .fault_code(w_fault_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- transaction-timeline model ----------------
    // cyc indexes the clock interval following each rising edge. A transaction
    // is described by the interval where ENC starts (t_acc), DEC starts (t_enc)
    // and the check runs (t_dec); done is the interval after the check.
    int             cyc = 0;
    int             t_acc = -1, t_enc = -1, t_dec = -1;
    logic [Y-1:0]   m_pt = '0, m_ct = '0, m_dp = '0, e_ct = '0;
    logic [127:0]   m_tag = '0, e_tag = '0;
    logic           e_fault = 1'b0;
    logic [1:0]     e_code = 2'b00;

    function automatic bit x_busy(input int c);
        return (t_acc >= 0) && (c >= t_acc) && ((t_dec < 0) || (c <= t_dec));
    endfunction
    function automatic bit x_enc(input int c);
        return (t_acc >= 0) && (c >= t_acc) && ((t_enc < 0) || (c < t_enc));
    endfunction
    function automatic bit x_dec(input int c);
        return (t_enc >= 0) && (c >= t_enc) && ((t_dec < 0) || (c < t_dec));
    endfunction
    function automatic bit x_done(input int c);
        return (t_dec >= 0) && (c == t_dec + 1);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                t_acc = -1; t_enc = -1; t_dec = -1;
                e_ct = '0; e_tag = '0; e_fault = 1'b0; e_code = 2'b00;
            end else if (!x_busy(cyc)) begin
                if (req) begin
                    t_acc = cyc + 1; t_enc = -1; t_dec = -1;
                    m_pt = plain_text; e_fault = 1'b0; e_code = 2'b00;
                end
            end else if (t_enc < 0) begin
                if (cyc > t_acc && encryption_ready) begin
                    t_enc = cyc + 1; m_ct = cipher_text; m_tag = tag;
                end
            end else if (t_dec < 0) begin
                if (cyc > t_enc && decryption_ready) begin
                    t_dec = cyc + 1; m_dp = dec_plain_text;
                end
            end else begin
                if (tag != m_tag) begin
                    e_fault = 1'b1; e_code = 2'b10; e_ct = '0; e_tag = '0;
                end else if (m_dp != m_pt) begin
                    e_fault = 1'b1; e_code = 2'b01; e_ct = '0; e_tag = '0;
                end else begin
                    e_ct = m_ct; e_tag = m_tag;
                end
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt = 0, last_lat = 0;
    int w_done_cnt = 0, w_lat = 0, w_dec_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_enc_start", 128'(encryption_start), 128'(0));
                chk("rst_dec_start", 128'(decryption_start), 128'(0));
                chk("rst_done", 128'(done), 128'(0));
                chk("rst_fault", 128'(fault), 128'(0));
                chk("rst_fault_code", 128'(fault_code), 128'(0));
                chk("rst_ct_out", 128'(ct_out), 128'(0));
                chk("rst_tag_out", tag_out, 128'(0));
            end else begin
                chk("busy", 128'(busy), 128'(x_busy(cyc)));
                chk("encryption_start", 128'(encryption_start), 128'(x_enc(cyc)));
                chk("decryption_start", 128'(decryption_start), 128'(x_dec(cyc)));
                chk("done", 128'(done), 128'(x_done(cyc)));
                chk("fault", 128'(fault), 128'(e_fault));
                chk("fault_code", 128'(fault_code), 128'(e_code));
                chk("ct_out", 128'(ct_out), 128'(e_ct));
                chk("tag_out", tag_out, e_tag);
            end
            if (done) begin
                done_cnt++;
                last_lat = cyc - t_acc + 1;
            end
            if (w_done) begin
                w_done_cnt++;
                w_lat = cyc - t_acc + 1;
            end
            if (w_decryption_start) w_dec_seen++;
        end
    end

    // ---------------- emulated datapath ----------------
    int             r_lat = 20;
    bit             r_stuck = 1'b0;
    bit             r_swap = 1'b0;
    logic [Y-1:0]   r_flip = '0;
    int             ecnt = 0, dcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (encryption_start && !r_stuck) ecnt++; else ecnt = 0;
            if (decryption_start) dcnt++; else dcnt = 0;
            encryption_ready = encryption_start && !r_stuck && (ecnt >= r_lat);
            decryption_ready = decryption_start && (dcnt >= r_lat);
            cipher_text = CT0;
            if (encryption_start) tag = TAG0;
            else if (decryption_start && r_swap) tag = TAG1;
            dec_plain_text = m_pt ^ r_flip;
            dec_tag = TAG0;
        end
    end

    // One transaction with plaintext PT0, then hand-computed expectations.
    task automatic run_tx(input string nm, input int lat, input logic [Y-1:0] flip, input bit swap,
                          input int x_lat, input logic x_fault, input logic [1:0] x_code,
                          input logic [Y-1:0] x_ct, input logic [127:0] x_tag);
        int d0;
        r_lat = lat; r_flip = flip; r_swap = swap;
        d0 = done_cnt;
        step();
        plain_text = PT0;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 200 && done_cnt == d0; k++) step();
        chk({nm, "_done_seen"}, 128'(done_cnt - d0), 128'(1));
        chk({nm, "_latency"}, 128'(last_lat), 128'(x_lat));
        chk({nm, "_fault"}, 128'(fault), 128'(x_fault));
        chk({nm, "_code"}, 128'(fault_code), 128'(x_code));
        chk({nm, "_ct_out"}, 128'(ct_out), 128'(x_ct));
        chk({nm, "_tag_out"}, tag_out, x_tag);
        repeat (10) step();
        chk({nm, "_done_once"}, 128'(done_cnt - d0), 128'(1));
        r_flip = '0; r_swap = 1'b0;
    endtask

    initial begin
        int d0, w0, wd0, lo, lo_nd;

        // Reset state.
        repeat (3) step();
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_outputs", {encryption_start, decryption_start, done, fault, fault_code}, 128'(0));
        chk("reset_ct_tag", {ct_out, tag_out[87:0]}, 128'(0));
        rst = 1'b1;
        repeat (2) step();

        // Correct datapath, 20-cycle ready: done at cycle 2*20+2.
        run_tx("good20", 20, '0, 1'b0, 42, 1'b0, 2'b00, CT0, TAG0);
        // Fastest datapath gives the 6-cycle minimum.
        run_tx("good2", 2, '0, 1'b0, 6, 1'b0, 2'b00, CT0, TAG0);
        // Ready already high in the first phase cycle must be ignored.
        run_tx("stale1", 1, '0, 1'b0, 6, 1'b0, 2'b00, CT0, TAG0);
        // Decrypted plaintext bit 0 flipped.
        run_tx("pt_flip", 20, 40'h1, 1'b0, 42, 1'b1, 2'b01, '0, '0);
        // Late tag change plus wrong plaintext: tag mismatch has priority.
        run_tx("tag_late", 3, 40'h1, 1'b1, 8, 1'b1, 2'b10, '0, '0);

        // Reset pulsed during DEC aborts at once with no done.
        r_lat = 20;
        step();
        plain_text = PT0;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 100 && !decryption_start; k++) step();
        chk("abort_reached_dec", 128'(decryption_start), 128'(1));
        step();
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_dec_start", 128'(decryption_start), 128'(0));
        chk("abort_enc_start", 128'(encryption_start), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_fault", {fault, fault_code}, 128'(0));
        chk("abort_ct_out", 128'(ct_out), 128'(0));
        chk("abort_tag_out", tag_out, 128'(0));
        d0 = done_cnt;
        repeat (3) step();
        rst = 1'b1;
        repeat (30) step();
        chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
        run_tx("after_abort", 20, '0, 1'b0, 42, 1'b0, 2'b00, CT0, TAG0);

        // req held high: back-to-back, idle only in each done cycle, plaintext
        // changes while busy are not captured.
        r_lat = 2;
        step();
        plain_text = PT0;
        req = 1'b1;
        d0 = done_cnt; lo = 0; lo_nd = 0;
        for (int k = 0; k < 400 && done_cnt < d0 + 3; k++) begin
            step();
            plain_text = {8'h00, 32'($urandom)};
            if (!busy) lo++;
            if (!busy && !done) lo_nd++;
        end
        req = 1'b0;
        chk("held_done_count", 128'(done_cnt - d0), 128'(3));
        chk("held_idle_cycles", 128'(lo), 128'(3));
        chk("held_idle_without_done", 128'(lo_nd), 128'(0));
        chk("held_fault", 128'(fault), 128'(0));
        repeat (5) step();

        // Encryption ready stuck low on the TIMEOUT=15 instance.
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        r_stuck = 1'b1;
        w0 = w_done_cnt; wd0 = w_dec_seen;
        step();
        plain_text = PT0;
        req = 1'b1;
        step();
        req = 1'b0;
`ifdef FC_TIMEOUT_EN
        for (int k = 0; k < 60 && w_done_cnt == w0; k++) step();
        chk("tmo_done_seen", 128'(w_done_cnt - w0), 128'(1));
        chk("tmo_latency", 128'(w_lat), 128'(17));
        chk("tmo_fault", 128'(w_fault), 128'(1));
        chk("tmo_code", 128'(w_fault_code), 128'(3));
        chk("tmo_ct_tag", {w_ct_out, w_tag_out[87:0]}, 128'(0));
        chk("tmo_busy", 128'(w_busy), 128'(0));
`else
        repeat (40) step();
        chk("wait_no_done", 128'(w_done_cnt - w0), 128'(0));
        chk("wait_busy", 128'(w_busy), 128'(1));
        chk("wait_enc_start", 128'(w_encryption_start), 128'(1));
        chk("wait_fault", {w_fault, w_fault_code}, 128'(0));
`endif
        chk("stuck_no_dec_start", 128'(w_dec_seen - wd0), 128'(0));
        r_stuck = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
